mem_ctl_multipage: RTL
======================

// Module: mem_ctl_multipage
// PURPOSE
//  Parametrised main-bus slave memory controller: decodes NUM_PAGES contiguous pages from BASE_PAGE,
//  runs fixed-length read/write bursts on the multiplexed AddrData bus, and drives a synchronous
//  memory array (1-cycle read latency). Adds multi-page decode, read wait states, wrap/linear bursts, protocol-error flag.
// PARAMETERS
//  ADDR_W       16     bus address width (= data width on the multiplexed bus)
//  PAGE_BITS    4      MS address bits forming the page number
//  BASE_PAGE    4'h2   first page decoded by this controller
//  NUM_PAGES    2      contiguous pages decoded (power of 2, >=1)
//  BURST_LEN    4      data words per transaction (power of 2, >=2)
//  WAIT_STATES  0      extra cycles before first read data word (0..7)
//  WRAP         1      1: burst address wraps in BURST_LEN-aligned block; 0: linear increment
//  MEM_AW       derived $clog2(NUM_PAGES)+ADDR_W-PAGE_BITS, memory address width (localparam)
// PORTS
//  clk           in   1        system clock, all logic on posedge
//  resetL        in   1        asynchronous active-low reset
//  AddrValid     in   1        address phase strobe from bus master
//  rw            in   1        sampled with AddrValid: 1=read, 0=write
//  AddrData_in   in   ADDR_W   bus address (address phase) / write data (data phase)
//  AddrData_out  out  ADDR_W   read data driven to bus
//  AddrData_oe   out  1        1 = controller owns bus this cycle
//  busy          out  1        1 = burst in progress
//  proto_err     out  1        1-cycle pulse: AddrValid seen while busy
//  mem_addr      out  MEM_AW   memory word address
//  mem_wdata     out  ADDR_W   memory write data
//  mem_we        out  1        memory write enable
//  mem_re        out  1        memory read enable
//  mem_rdata     in   ADDR_W   memory read data, valid cycle after mem_re
// BEHAVIOUR
//  - Reset (resetL=0, async): state IDLE; all outputs 0; counters cleared; partial burst abandoned, no further mem_we/mem_re.
//  - Decode at T0 (AddrValid=1 in IDLE): page=AddrData_in[ADDR_W-1 -: PAGE_BITS]; hit iff BASE_PAGE<=page<BASE_PAGE+NUM_PAGES.
//    Miss: stay IDLE, no mem activity, oe stays 0. Hit: offset={page-BASE_PAGE, AddrData_in[ADDR_W-PAGE_BITS-1:0]}.
//  - FSM: IDLE -> WR (hit, rw=0); IDLE -> RD_WAIT (hit, rw=1, WAIT_STATES>0) or RD (WAIT_STATES=0);
//    RD_WAIT -> RD after WAIT_STATES cycles; WR/RD -> IDLE after BURST_LEN words (a drain cycle for the last read word). busy=1 outside IDLE.
//  - Write: master drives word k (k=0..BURST_LEN-1) at T(1+k); registered mem_we=1, mem_wdata=word k,
//    mem_addr=addr_k at T(2+k). Wait states do not apply to writes.
//  - Read: mem_re=1, mem_addr=addr_k at T(1+WAIT_STATES+k); AddrData_out=mem_rdata, AddrData_oe=1 at
//    T(2+WAIT_STATES+k). oe low in every other cycle; AddrData_out=0 when oe=0.
//  - addr_k: WRAP=1 -> upper bits fixed, low log2(BURST_LEN) bits = (start+k) mod BURST_LEN;
//    WRAP=0 -> start+k modulo 2**MEM_AW (may cross into next decoded page; wraps at top of region).
//  - AddrValid while busy: ignored (current burst completes unaltered), proto_err=1 next cycle.
//  - AddrValid at the cycle the FSM returns to IDLE is accepted as a new T0 (back-to-back bursts, no idle gap required).
//  - mem_we and mem_re never both 1; at most one memory op per cycle.
// TESTING
//  1 Write 0x2010, data A,B,C,D -> mem_we T2..T5, mem_addr 0x010,0x011,0x012,0x013, mem_wdata A..D.
//  2 Read 0x2010, WAIT_STATES=0 -> oe=1 T2..T5, AddrData_out A,B,C,D; WAIT_STATES=2 -> oe T4..T7, same data.
//  3 WRAP=1 read 0x2012 -> mem_addr 0x012,0x013,0x010,0x011; WRAP=0 -> 0x012..0x015.
//  4 Write 0x3004 -> mem_addr 0x1004..0x1007; access 0x5004 (miss) -> no mem_we/mem_re, oe=0, busy=0.
//  5 AddrValid at T2 of read burst -> proto_err pulse at T3, original 4 words returned unchanged.
//  6 resetL=0 at T3 of write burst -> outputs 0 immediately, no mem_we afterwards; next 0x2020 write completes normally.

Source files
------------

// File: rtl/mem_ctl_multipage_if.sv
// Bus and memory-side signals of the multi-page memory controller.
// slave = controller view, master = bus master plus memory view.
interface mem_ctl_multipage_if #(
   parameter int ADDR_W = 16,
   parameter int MEM_AW = 13
);
   logic              AddrValid;
   logic              rw;
   logic [ADDR_W-1:0] AddrData_in;
   logic [ADDR_W-1:0] AddrData_out;
   logic              AddrData_oe;
   logic              busy;
   logic              proto_err;
   logic [MEM_AW-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_rdata;

   modport slave (
      input  AddrValid, rw, AddrData_in, mem_rdata,
      output AddrData_out, AddrData_oe, busy, proto_err,
             mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output AddrValid, rw, AddrData_in, mem_rdata,
      input  AddrData_out, AddrData_oe, busy, proto_err,
             mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/mem_ctl_multipage.sv
// Multi-page bus slave: decodes NUM_PAGES pages from BASE_PAGE and runs fixed bursts on a sync memory.
// Latency: write word lands 1 cycle after it is driven, read data 2+WAIT_STATES cycles after address; no backpressure, AddrValid while busy is dropped and flagged.
module mem_ctl_multipage #(
   parameter int ADDR_W      = 16,
   parameter int PAGE_BITS   = 4,
   parameter int BASE_PAGE   = 'h2,
   parameter int NUM_PAGES   = 2,
   parameter int BURST_LEN   = 4,
   parameter int WAIT_STATES = 0,
   parameter int WRAP        = 1
) (
   input  logic clk,
   input  logic resetL,
   mem_ctl_multipage_if.slave bus
);
   localparam int PB     = $clog2(NUM_PAGES);
   localparam int MEM_AW = PB + ADDR_W - PAGE_BITS;
   localparam int LB     = $clog2(BURST_LEN);
   localparam int CW     = LB + 1;
   localparam logic [PAGE_BITS:0] PG_LO = (PAGE_BITS+1)'(BASE_PAGE);
   localparam logic [PAGE_BITS:0] PG_HI = (PAGE_BITS+1)'(BASE_PAGE + NUM_PAGES);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD, WR} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          wcnt_q, wcnt_d;
   logic [MEM_AW-1:0]   start_q, start_d;
   logic                mem_we_q, mem_re_q, oe_q, perr_q;
   logic [MEM_AW-1:0]   mem_addr_q;
   logic [ADDR_W-1:0]   mem_wdata_q;

   logic                issue_we, issue_re;
   logic [CW-1:0]       beat;
   logic [MEM_AW-1:0]   base, beat_addr, in_off;
   logic [PAGE_BITS-1:0] page;
   logic                hit;

   assign page   = bus.AddrData_in[ADDR_W-1 -: PAGE_BITS];
   assign hit    = ({1'b0, page} >= PG_LO) && ({1'b0, page} < PG_HI);
   // Relative page number in the top bits keeps consecutive pages contiguous in memory.
   assign in_off = MEM_AW'({page - PAGE_BITS'(BASE_PAGE), bus.AddrData_in[ADDR_W-PAGE_BITS-1:0]});

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      start_d  = start_q;
      issue_we = 1'b0;
      issue_re = 1'b0;
      beat     = cnt_q;
      base     = start_q;
      case (state_q)
         IDLE: begin
            if (bus.AddrValid && hit) begin
               start_d = in_off;
               cnt_d   = '0;
               wcnt_d  = '0;
               if (!bus.rw) begin
                  state_d = WR;
               end else if (WAIT_STATES == 0) begin
                  // No wait states: first read goes out straight from the address phase.
                  issue_re = 1'b1;
                  base     = in_off;
                  beat     = '0;
                  cnt_d    = CW'(1);
                  state_d  = RD;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == 3'(WAIT_STATES - 1)) begin
               issue_re = 1'b1;
               beat     = '0;
               cnt_d    = CW'(1);
               state_d  = RD;
            end
         end
         RD: begin
            // Extra cycle after the last issue covers the final word still in flight.
            if (cnt_q < CW'(BURST_LEN)) begin
               issue_re = 1'b1;
               cnt_d    = cnt_q + 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         WR: begin
            issue_we = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(BURST_LEN - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (WRAP != 0) beat_addr = {base[MEM_AW-1:LB], base[LB-1:0] + beat[LB-1:0]};
      else           beat_addr = base + MEM_AW'(beat);
   end

   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         start_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         oe_q        <= 1'b0;
         perr_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         start_q  <= start_d;
         mem_we_q <= issue_we;
         mem_re_q <= issue_re;
         oe_q     <= mem_re_q;
         perr_q   <= bus.AddrValid && (state_q != IDLE);
         if (issue_we || issue_re) mem_addr_q <= beat_addr;
         if (issue_we) mem_wdata_q <= bus.AddrData_in;
      end
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.proto_err    = perr_q;
   assign bus.AddrData_oe  = oe_q;
   assign bus.AddrData_out = oe_q ? bus.mem_rdata : '0;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_re       = mem_re_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
endmodule
